// File: rtl/adxl_sample_assembler_pkg.sv
// Shared constants and state encoding for the ADXL345 sample assembler.
// Axis indices also select the byte pair {byte(2k+1), byte(2k)} for each axis.
package adxl_sample_assembler_pkg;

   localparam int AXIS_X    = 0;
   localparam int AXIS_Y    = 1;
   localparam int AXIS_Z    = 2;
   localparam int NUM_AXES  = 3;
   localparam int BURST_LEN = 6;

   typedef enum logic [1:0] {
      ST_WAIT_START = 2'd0,
      ST_COLLECT    = 2'd1,
      ST_PUBLISH    = 2'd2
   } state_t;

endpackage

// File: rtl/adxl_axis_issue.sv
// Per-axis issue stage: keeps the sample stable for one filter and tracks busy.
// A sample is dropped when the filter is busy and not finishing in the same cycle.
module adxl_axis_issue #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  i_rstn,
   input  logic                  i_publish,
   input  logic [DATA_WIDTH-1:0] i_sample,
   input  logic                  i_done,
   output logic                  o_dataval,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_busy,
   output logic                  o_drop
);

   logic                  w_issue;
   logic                  r_dataval;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_data;

   assign w_issue = i_publish & (~r_busy | i_done);
   assign o_drop  = i_publish & r_busy & ~i_done;

   // A new issue wins over a same-cycle done, so busy stays set for the fresh sample.
   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         r_dataval <= 1'b0;
         r_busy    <= 1'b0;
         r_data    <= '0;
      end else begin
         r_dataval <= w_issue;
         if (w_issue) begin
            r_data <= i_sample;
            r_busy <= 1'b1;
         end else if (i_done) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_dataval = r_dataval;
   assign o_data    = r_data;
   assign o_busy    = r_busy;

endmodule

// File: rtl/adxl_sample_assembler.sv
// Collects the 6-byte DATAX0..DATAZ1 burst, sign-extends each axis and hands the
// samples to three per-axis issue stages; counts aborted bursts and dropped samples.
module adxl_sample_assembler
   import adxl_sample_assembler_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int SAMPLE_BITS = 13,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  i_rstn,
   input  logic                  i_byte_valid,
   input  logic [7:0]            i_byte,
   input  logic                  i_burst_start,
   input  logic                  i_done_x,
   input  logic                  i_done_y,
   input  logic                  i_done_z,
   output logic                  o_dataval_x,
   output logic                  o_dataval_y,
   output logic                  o_dataval_z,
   output logic [DATA_WIDTH-1:0] o_data_x,
   output logic [DATA_WIDTH-1:0] o_data_y,
   output logic [DATA_WIDTH-1:0] o_data_z,
   output logic [2:0]            o_busy,
   output logic                  o_overrun,
   output logic [CNT_WIDTH-1:0]  o_overrun_cnt,
   output logic [CNT_WIDTH-1:0]  o_frame_err_cnt
);

   localparam int SHIFT = 16 - SAMPLE_BITS;

   state_t               r_state;
   logic [2:0]           r_idx;
   logic [7:0]           r_buf [BURST_LEN];
   logic                 r_overrun;
   logic [CNT_WIDTH-1:0] r_overrunCnt;
   logic [CNT_WIDTH-1:0] r_frameErrCnt;

   logic                  w_publish;
   logic [NUM_AXES-1:0]   w_done;
   logic [NUM_AXES-1:0]   w_dataval;
   logic [NUM_AXES-1:0]   w_busy;
   logic [NUM_AXES-1:0]   w_drop;
   logic [DATA_WIDTH-1:0] w_sample [NUM_AXES];
   logic [DATA_WIDTH-1:0] w_data   [NUM_AXES];
   logic [1:0]            w_dropNum;
   logic [CNT_WIDTH:0]    w_ovfSum;

   assign w_publish = (r_state == ST_PUBLISH);
   assign w_done    = {i_done_z, i_done_y, i_done_x};

   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         r_state       <= ST_WAIT_START;
         r_idx         <= '0;
         r_frameErrCnt <= '0;
         for (int i = 0; i < BURST_LEN; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (i_byte_valid && i_burst_start) begin
                  r_buf[0] <= i_byte;
                  r_idx    <= 3'd1;
                  if (r_frameErrCnt != '1) r_frameErrCnt <= r_frameErrCnt + 1'b1;
               end else if (i_byte_valid) begin
                  r_buf[r_idx] <= i_byte;
                  r_idx        <= r_idx + 3'd1;
                  if (r_idx == 3'(BURST_LEN - 1)) r_state <= ST_PUBLISH;
               end
            end
            default: begin
               // PUBLISH lasts one cycle but must not lose a burst start arriving in it.
               if (i_byte_valid && i_burst_start) begin
                  r_buf[0] <= i_byte;
                  r_idx    <= 3'd1;
                  r_state  <= ST_COLLECT;
               end else begin
                  r_state  <= ST_WAIT_START;
               end
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
      logic [15:0]        w_raw;
      logic signed [15:0] w_shl;
      logic signed [15:0] w_ext;

      assign w_raw       = {r_buf[2*k+1], r_buf[2*k]};
      assign w_shl       = $signed(w_raw << SHIFT);
      assign w_ext       = w_shl >>> SHIFT;
      assign w_sample[k] = DATA_WIDTH'(w_ext);

      adxl_axis_issue #(.DATA_WIDTH(DATA_WIDTH)) u_issue (
         .clk       (clk),
         .i_rstn    (i_rstn),
         .i_publish (w_publish),
         .i_sample  (w_sample[k]),
         .i_done    (w_done[k]),
         .o_dataval (w_dataval[k]),
         .o_data    (w_data[k]),
         .o_busy    (w_busy[k]),
         .o_drop    (w_drop[k])
      );
   end

   assign w_dropNum = 2'(w_drop[0]) + 2'(w_drop[1]) + 2'(w_drop[2]);
   assign w_ovfSum  = {1'b0, r_overrunCnt} + (CNT_WIDTH+1)'(w_dropNum);

   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         r_overrun    <= 1'b0;
         r_overrunCnt <= '0;
      end else begin
         r_overrun <= |w_drop;
         if (w_ovfSum[CNT_WIDTH]) r_overrunCnt <= '1;
         else                     r_overrunCnt <= w_ovfSum[CNT_WIDTH-1:0];
      end
   end

   assign o_dataval_x     = w_dataval[AXIS_X];
   assign o_dataval_y     = w_dataval[AXIS_Y];
   assign o_dataval_z     = w_dataval[AXIS_Z];
   assign o_data_x        = w_data[AXIS_X];
   assign o_data_y        = w_data[AXIS_Y];
   assign o_data_z        = w_data[AXIS_Z];
   assign o_busy          = w_busy;
   assign o_overrun       = r_overrun;
   assign o_overrun_cnt   = r_overrunCnt;
   assign o_frame_err_cnt = r_frameErrCnt;

endmodule

// File: tb/tb_adxl_sample_assembler.sv
// Directed bench for adxl_sample_assembler: a full-res (13-bit) instance plus a
// 10-bit instance sharing the same byte stream for the sign-extension case.
module tb_adxl_sample_assembler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        byteValid;
   logic [7:0]  byteIn;
   logic        burstStart;
   logic        doneX, doneY, doneZ;

   logic        dvX, dvY, dvZ;
   logic [15:0] dataX, dataY, dataZ;
   logic [2:0]  busy;
   logic        overrun;
   logic [7:0]  ovfCnt, ferrCnt;

   logic        dvX10, dvY10, dvZ10;
   logic [15:0] dataX10, dataY10, dataZ10;
   logic [2:0]  busy10;
   logic        overrun10;
   logic [7:0]  ovfCnt10, ferrCnt10;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adxl_sample_assembler #(.DATA_WIDTH(16), .SAMPLE_BITS(13), .CNT_WIDTH(8)) dut (
      .clk(clk), .i_rstn(rstn), .i_byte_valid(byteValid), .i_byte(byteIn),
      .i_burst_start(burstStart), .i_done_x(doneX), .i_done_y(doneY), .i_done_z(doneZ),
      .o_dataval_x(dvX), .o_dataval_y(dvY), .o_dataval_z(dvZ),
      .o_data_x(dataX), .o_data_y(dataY), .o_data_z(dataZ),
      .o_busy(busy), .o_overrun(overrun), .o_overrun_cnt(ovfCnt), .o_frame_err_cnt(ferrCnt)
   );

   adxl_sample_assembler #(.DATA_WIDTH(16), .SAMPLE_BITS(10), .CNT_WIDTH(8)) dut10 (
      .clk(clk), .i_rstn(rstn), .i_byte_valid(byteValid), .i_byte(byteIn),
      .i_burst_start(burstStart), .i_done_x(doneX), .i_done_y(doneY), .i_done_z(doneZ),
      .o_dataval_x(dvX10), .o_dataval_y(dvY10), .o_dataval_z(dvZ10),
      .o_data_x(dataX10), .o_data_y(dataY10), .o_data_z(dataZ10),
      .o_busy(busy10), .o_overrun(overrun10), .o_overrun_cnt(ovfCnt10), .o_frame_err_cnt(ferrCnt10)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one byte for exactly one rising edge, then returns #1 after that edge.
   task automatic applyStimulus(input logic [7:0] b, input logic start);
      byteValid  = 1'b1;
      byteIn     = b;
      burstStart = start;
      @(posedge clk); #1;
      byteValid  = 1'b0;
      burstStart = 1'b0;
   endtask

   task automatic sendBurst(input logic [7:0] b0, b1, b2, b3, b4, b5);
      applyStimulus(b0, 1'b1);
      applyStimulus(b1, 1'b0);
      applyStimulus(b2, 1'b0);
      applyStimulus(b3, 1'b0);
      applyStimulus(b4, 1'b0);
      applyStimulus(b5, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      rstn = 1'b0; byteValid = 1'b0; byteIn = '0; burstStart = 1'b0;
      doneX = 1'b0; doneY = 1'b0; doneZ = 1'b0;
      tick(); tick();

      checkOutput("rst_dataval", {dvX, dvY, dvZ}, 3'b000);
      checkOutput("rst_data_x", dataX, 16'h0000);
      checkOutput("rst_busy", busy, 3'b000);
      checkOutput("rst_overrun", overrun, 1'b0);
      checkOutput("rst_ovf_cnt", ovfCnt, 8'h00);
      checkOutput("rst_ferr_cnt", ferrCnt, 8'h00);
      rstn = 1'b1;
      tick();

      // Full-res burst: issued on all three axes one cycle after the last byte.
      sendBurst(8'h05, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h10);
      checkOutput("a_dv_before", {dvX, dvY, dvZ}, 3'b000);
      tick();
      checkOutput("a_dataval", {dvX, dvY, dvZ}, 3'b111);
      checkOutput("a_data_x", dataX, 16'h0005);
      checkOutput("a_data_y", dataY, 16'hFFFF);
      checkOutput("a_data_z", dataZ, 16'hF000);
      checkOutput("a_busy", busy, 3'b111);
      checkOutput("a_overrun", overrun, 1'b0);
      tick();
      checkOutput("a_dv_pulse", {dvX, dvY, dvZ}, 3'b000);

      // Second burst with all filters busy: every axis dropped.
      sendBurst(8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00);
      tick();
      checkOutput("b_dataval", {dvX, dvY, dvZ}, 3'b000);
      checkOutput("b_overrun", overrun, 1'b1);
      checkOutput("b_ovf_cnt", ovfCnt, 8'd3);
      checkOutput("b_data_x", dataX, 16'h0005);
      checkOutput("b_data_z", dataZ, 16'hF000);
      tick();
      checkOutput("b_overrun_pulse", overrun, 1'b0);

      // done_x in the PUBLISH cycle lets X through; Y/Z still dropped.
      sendBurst(8'h10, 8'h00, 8'h44, 8'h00, 8'h55, 8'h00);
      doneX = 1'b1;
      tick();
      doneX = 1'b0;
      checkOutput("c_dataval", {dvZ, dvY, dvX}, 3'b001);
      checkOutput("c_data_x", dataX, 16'h0010);
      checkOutput("c_data_y", dataY, 16'hFFFF);
      checkOutput("c_overrun", overrun, 1'b1);
      checkOutput("c_ovf_cnt", ovfCnt, 8'd5);
      checkOutput("c_busy", busy, 3'b111);

      doneX = 1'b1; doneY = 1'b1; doneZ = 1'b1;
      tick();
      doneX = 1'b0; doneY = 1'b0; doneZ = 1'b0;
      checkOutput("d_busy_clear", busy, 3'b000);
      doneY = 1'b1;
      tick();
      doneY = 1'b0;
      checkOutput("d_idle_done", busy, 3'b000);

      // Burst restarted on the third byte.
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h07, 1'b1);
      checkOutput("e_ferr_cnt", ferrCnt, 8'd1);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h08, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h09, 1'b0);
      checkOutput("e_no_early_dv", {dvX, dvY, dvZ}, 3'b000);
      applyStimulus(8'h00, 1'b0);
      tick();
      checkOutput("e_dataval", {dvX, dvY, dvZ}, 3'b111);
      checkOutput("e_data_x", dataX, 16'h0007);
      checkOutput("e_data_y", dataY, 16'h0008);
      checkOutput("e_data_z", dataZ, 16'h0009);
      checkOutput("e_ovf_cnt", ovfCnt, 8'd5);

      // Reset after four bytes discards the partial burst.
      applyStimulus(8'hAA, 1'b1);
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'hCC, 1'b0);
      applyStimulus(8'hDD, 1'b0);
      rstn = 1'b0;
      tick();
      checkOutput("f_rst_data_x", dataX, 16'h0000);
      checkOutput("f_rst_busy", busy, 3'b000);
      checkOutput("f_rst_ferr", ferrCnt, 8'h00);
      checkOutput("f_rst_ovf", ovfCnt, 8'h00);
      rstn = 1'b1;
      applyStimulus(8'hEE, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      tick();
      checkOutput("f_no_dv", {dvX, dvY, dvZ}, 3'b000);
      checkOutput("f_no_busy", busy, 3'b000);

      sendBurst(8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      checkOutput("g_dataval", {dvX, dvY, dvZ}, 3'b111);
      checkOutput("g_data_x13", dataX, 16'h0200);
      checkOutput("g_data_x10", dataX10, 16'hFE00);
      checkOutput("g_data_y10", dataY10, 16'h0000);

      // 100 back-to-back bursts while busy: 300 drops saturate the counter.
      for (int n = 0; n < 100; n++) begin
         sendBurst(8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00);
         if (n == 83) begin
            tick();
            checkOutput("h_ovf_252", ovfCnt, 8'd252);
         end
      end
      tick();
      checkOutput("h_ovf_sat", ovfCnt, 8'hFF);
      checkOutput("h_data_hold", dataX, 16'h0200);
      tick();
      checkOutput("h_ovf_sat_hold", ovfCnt, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adxl_sample_assembler.md
Name: adxl_sample_assembler

Overview:
Sits between the ADXL345 SPI burst reader and the three per-axis 4-sample moving-average filters. Consumes the 6-byte DATAX0..DATAZ1 burst byte stream. Assembles little-endian signed X/Y/Z samples and sign-extends them from the device resolution. Drives each filter's dataval/data_in pair, holding data stable until that filter's filtering_completed, and detects framing errors and overruns.

Parameters:
DATA_WIDTH, 16, width of each output sample (matches filter DATA_WIDTH)
SAMPLE_BITS, 13, significant device bits (10 fixed-res, 13 full-res); legal range 8..DATA_WIDTH
CNT_WIDTH, 8, width of the saturating error counters

Ports:
clk  in  1  system clock
i_rstn  in  1  synchronous active-low reset
i_byte_valid  in  1  one-cycle strobe, i_byte valid
i_byte  in  8  burst byte
i_burst_start  in  1  qualifies i_byte_valid: byte is DATAX0 (first of burst)
i_done_x / i_done_y / i_done_z  in  1 each  filtering_completed from X/Y/Z filter
o_dataval_x / o_dataval_y / o_dataval_z  out  1 each  one-cycle sample strobe to filter
o_data_x / o_data_y / o_data_z  out  DATA_WIDTH each  signed sample to filter data_in
o_busy  out  3  {z,y,x} filter-busy flags
o_overrun  out  1  one-cycle pulse when any axis sample is dropped
o_overrun_cnt  out  CNT_WIDTH  saturating dropped-sample count
o_frame_err_cnt  out  CNT_WIDTH  saturating aborted-burst count

Behaviour:
- Reset (i_rstn=0 at posedge): all outputs 0, byte index 0, state WAIT_START, byte buffer cleared. Mid-burst reset discards the partial burst. Busy flags clear; no dataval is issued until a fresh burst completes.
- States:
  - WAIT_START: ignore valid bytes without i_burst_start. Valid byte with i_burst_start -> store as byte0, idx=1, go to COLLECT.
  - COLLECT: each valid byte is stored at buffer[idx], then idx++. Storing byte 5 -> PUBLISH.
  - COLLECT, valid byte with i_burst_start: burst aborted, o_frame_err_cnt++ (saturating). That byte becomes byte0 of the new burst, idx=1, stay in COLLECT.
  - PUBLISH: one cycle, then -> WAIT_START. Bytes arriving in PUBLISH are handled exactly as in WAIT_START, with no loss.
- Assembly: raw = {byte(2k+1), byte(2k)} for axis k (X=0, Y=1, Z=2). Sample = raw[SAMPLE_BITS-1:0] sign-extended to DATA_WIDTH; bits above SAMPLE_BITS are ignored.
- PUBLISH, per axis, evaluated independently:
  - busy clear, or i_done for that axis asserted this same cycle: load o_data_*, pulse o_dataval_* next cycle, set busy.
  - otherwise: sample dropped, o_data_* unchanged, o_overrun pulses, o_overrun_cnt += number of dropped axes (saturating).
- Busy handling: i_done_* clears busy. A simultaneous done and publish on one axis leaves busy set, because the new sample is issued.
- Latency: 6th byte accepted at posedge N; state PUBLISH during cycle N..N+1; o_dataval_* high for exactly cycle N+1..N+2.
- Data stability: o_data_* changes only at publish. It is held from the dataval pulse until the corresponding done, as the filter samples data_in one cycle after dataval.
- i_done_* while not busy: ignored.
- Counters saturate at all-ones and never wrap.
- o_overrun and o_dataval_* are never high for more than one consecutive cycle per publish.

Decomposition:
- Shared package: axis index constants (AXIS_X=0, AXIS_Y=1, AXIS_Z=2), state encodings, BURST_LEN=6.
- Natural sub-module: adxl_axis_issue, one per axis. Holds the busy flag, data hold register, dataval pulse and drop detect. Top level does byte collection, sign-extension, FSM and counters.

Test Plan:
- Full-res burst 0x05,0x00,0xFF,0x1F,0x00,0x10 (SAMPLE_BITS=13): next cycle o_dataval_x/y/z=1 for one cycle; o_data_x=0x0005, o_data_y=0xFFFF, o_data_z=0xF000; o_busy=3'b111.
- Second burst before any i_done: no dataval; o_overrun one pulse; o_overrun_cnt=3; o_data_* unchanged.
- i_done_x asserted in the PUBLISH cycle of a burst with X=0x0010: X issued (o_data_x=0x0010), Y/Z dropped, o_overrun_cnt +2, o_busy[0] stays 1.
- i_burst_start on 3rd byte: o_frame_err_cnt=1; the following 5 bytes complete a burst and publish normally.
- Reset asserted after 4 bytes: outputs 0, no dataval. A subsequent clean burst publishes with correct values. SAMPLE_BITS=10 with raw 0x0200 gives 0xFE00.
- Drive 300 overruns with CNT_WIDTH=8: o_overrun_cnt saturates at 0xFF.
